// File: rtl/aria_key_sched_ctrl.sv
// ARIA key-schedule sequencer: runs the W-expansion steps, then streams round keys in consumption order.
// Latency: first wr_en the cycle after the final w_ack; valid one cycle after issue. Stalled keys are replayed.
module aria_key_sched_ctrl #(
    parameter int ADDR_W  = 5,
    parameter int N_WSTEP = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        aria_mode,
    input  logic              decrypt,
    output logic              w_req,
    output logic [1:0]        w_idx,
    input  logic              w_ack,
    input  logic              rk_ready,
    output logic [ADDR_W-1:0] addr,
    output logic              wr_en,
    output logic              enc_round,
    output logic              dec_round,
    output logic              addr_last,
    output logic              addr_zero,
    output logic              rk_valid,
    output logic [4:0]        rk_num,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {IDLE, WREQ, WWAIT, GEN, FIN} state_t;

    localparam logic [1:0] LAST_STEP = 2'(N_WSTEP - 1);

    state_t     state;
    logic [1:0] step;
    logic [4:0] nxt;
    logic [4:0] last_q;
    logic       dec_q;

    logic       in_gen;
    logic       replay;
    logic       final_acc;
    logic       issue_new;
    logic [4:0] issue_idx;
    logic [4:0] map_idx;

    // The generator clobbers rkey whenever wr_en is low, so a stalled key must be re-issued.
    assign in_gen    = (state == GEN);
    assign replay    = in_gen & rk_valid & ~rk_ready;
    assign final_acc = in_gen & rk_valid & rk_ready & (rk_num == last_q);
    assign issue_new = in_gen & ~replay & ~final_acc & (nxt <= last_q);
    assign wr_en     = replay | issue_new;
    assign issue_idx = replay ? rk_num : nxt;
    assign map_idx   = dec_q ? (last_q - issue_idx) : issue_idx;
    assign addr      = wr_en ? ADDR_W'(map_idx) : '0;
    assign addr_last = wr_en & (map_idx == last_q);
    assign addr_zero = wr_en & (map_idx == 5'd0);
    assign enc_round = in_gen & ~dec_q;
    assign dec_round = in_gen & dec_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            step     <= '0;
            nxt      <= '0;
            last_q   <= '0;
            dec_q    <= 1'b0;
            w_req    <= 1'b0;
            w_idx    <= '0;
            rk_valid <= 1'b0;
            rk_num   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            rk_valid <= wr_en;
            rk_num   <= wr_en ? issue_idx : rk_num;
            w_req    <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (aria_mode)
                            2'b00:   last_q <= 5'd12;
                            2'b01:   last_q <= 5'd14;
                            default: last_q <= 5'd16;
                        endcase
                        dec_q <= decrypt;
                        step  <= '0;
                        nxt   <= '0;
                        w_idx <= '0;
                        w_req <= 1'b1;
                        busy  <= 1'b1;
                        state <= WREQ;
                    end
                end
                WREQ: state <= WWAIT;
                WWAIT: begin
                    if (w_ack) begin
                        if (step < LAST_STEP) begin
                            step  <= step + 2'd1;
                            w_idx <= step + 2'd1;
                            w_req <= 1'b1;
                            state <= WREQ;
                        end else begin
                            nxt   <= '0;
                            state <= GEN;
                        end
                    end
                end
                GEN: begin
                    if (issue_new)
                        nxt <= nxt + 5'd1;
                    if (final_acc) begin
                        done  <= 1'b1;
                        state <= FIN;
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aria_key_sched_ctrl.sv
// Bench for aria_key_sched_ctrl: scenario table plus randomized schedules checked against a key-order model.
module tb_aria_key_sched_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] aria_mode;
    logic       decrypt;
    logic       w_req;
    logic [1:0] w_idx;
    logic       w_ack;
    logic       rk_ready;
    logic [4:0] addr;
    logic       wr_en;
    logic       enc_round;
    logic       dec_round;
    logic       addr_last;
    logic       addr_zero;
    logic       rk_valid;
    logic [4:0] rk_num;
    logic       busy;
    logic       done;

    int passed = 0;
    int total  = 0;

    aria_key_sched_ctrl #(.ADDR_W(5), .N_WSTEP(3)) dut (
        .clk(clk), .rst(rst), .start(start), .aria_mode(aria_mode), .decrypt(decrypt),
        .w_req(w_req), .w_idx(w_idx), .w_ack(w_ack), .rk_ready(rk_ready),
        .addr(addr), .wr_en(wr_en), .enc_round(enc_round), .dec_round(dec_round),
        .addr_last(addr_last), .addr_zero(addr_zero), .rk_valid(rk_valid),
        .rk_num(rk_num), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        bit         dec;
        int         d0, d1, d2;
        int         stall_at;
        int         stall_len;
        bit         rnd_ready;
        bit         inject;
        int         abort_at;
        int         exp_keys;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int last_of(input logic [1:0] mode);
        return (mode == 2'b00) ? 12 : (mode == 2'b01) ? 14 : 16;
    endfunction

    // Address the generator must see for the k-th consumed key.
    function automatic int map_k(input int k, input bit dec, input int last);
        return dec ? (last - k) : k;
    endfunction

    function automatic logic [20:0] all_outs();
        return {w_req, w_idx, addr, wr_en, enc_round, dec_round, addr_last, addr_zero,
                rk_valid, rk_num, busy, done};
    endfunction

    task automatic run(input vec_t v);
        int last = last_of(v.mode);
        int dly[3];
        int cyc = 0, wreq_cnt = 0, acks = 0, last_ack_cyc = -1, ack_at = -1;
        int first_issue = -1, last_valid_cyc = -1, n_acc = 0, done_cnt = 0;
        int stall_left = v.stall_len, prev_addr = 0;
        bit prev_wr = 0, exp_done = 0, stalled_any = 0, injected = 0, aborted = 0;
        bit gen_phase;
        dly[0] = v.d0; dly[1] = v.d1; dly[2] = v.d2;

        @(posedge clk); #1;
        aria_mode = v.mode; decrypt = v.dec; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; aria_mode = ~v.mode; decrypt = ~v.dec;
        w_ack = 1'b0; rk_ready = 1'b1;

        forever begin
            @(negedge clk);
            chk("busy_during_run", busy, 1);
            if (w_req) begin
                chk("w_idx", w_idx, wreq_cnt);
                if (wreq_cnt < 3) ack_at = cyc + dly[wreq_cnt];
                wreq_cnt++;
            end
            if (w_ack && cyc == ack_at) begin
                acks++;
                last_ack_cyc = cyc;
            end
            if (done || exp_done) chk("done_pulse", done, exp_done);
            if (done) done_cnt++;
            exp_done = rk_valid && rk_ready && (rk_num == last);
            gen_phase = (acks == 3) && (cyc > last_ack_cyc) && (done_cnt == 0);
            if (!gen_phase)
                chk("quiet_outside_gen", {wr_en, enc_round, dec_round}, 0);
            else
                chk("round_flags", {enc_round, dec_round}, v.dec ? 2'b01 : 2'b10);
            if (wr_en) begin
                if (first_issue < 0) begin
                    first_issue = cyc;
                    chk("first_issue_latency", cyc - last_ack_cyc, 1);
                end
                chk("addr_zero", addr_zero, addr == 0);
                chk("addr_last", addr_last, addr == last);
            end
            if (rk_valid) begin
                chk("valid_follows_issue", prev_wr, 1);
                chk("rk_addr_map", prev_addr, map_k(rk_num, v.dec, last));
                if (rk_ready) begin
                    chk("key_order", rk_num, n_acc);
                    n_acc++;
                    if (rk_num < last)
                        chk("next_issue", wr_en ? addr : 99, map_k(rk_num + 1, v.dec, last));
                    else begin
                        chk("no_issue_after_final", wr_en, 0);
                        last_valid_cyc = cyc;
                    end
                end else begin
                    stalled_any = 1;
                    chk("replay", wr_en ? addr : 99, map_k(rk_num, v.dec, last));
                end
            end
            prev_wr = wr_en;
            prev_addr = addr;
            if (done_cnt > 0) break;
            if (cyc > 500) begin
                chk("schedule_timeout", done_cnt, 1);
                break;
            end

            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            w_ack = (cyc == ack_at);
            if (v.inject && !injected && rk_valid && rk_num == 3) begin
                start = 1'b1;
                w_ack = 1'b1;
                injected = 1;
            end
            rk_ready = 1'b1;
            if (v.rnd_ready) rk_ready = ($urandom_range(0, 99) < 70);
            if (rk_valid && rk_num == v.stall_at && stall_left > 0) begin
                rk_ready = 1'b0;
                stall_left--;
            end
            if (v.abort_at >= 0 && rk_valid && rk_num == v.abort_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0; start = 1'b0; w_ack = 1'b0;
                @(negedge clk);
                chk("abort_outputs_zero", all_outs(), 0);
                @(negedge clk);
                chk("abort_stays_idle", {busy, done, wr_en}, 0);
                aborted = 1;
                break;
            end
        end

        if (!aborted) begin
            chk("keys_accepted", n_acc, v.exp_keys);
            chk("done_count", done_cnt, 1);
            chk("w_req_count", wreq_cnt, 3);
            if (!stalled_any) chk("last_valid_time", last_valid_cyc - first_issue, last + 1);
            @(posedge clk); #1;
            start = 1'b0; w_ack = 1'b0; rk_ready = 1'b0;
            @(negedge clk);
            chk("idle_after_done", {busy, done, rk_valid}, 0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; aria_mode = 2'b00; decrypt = 1'b0;
        w_ack = 1'b0; rk_ready = 1'b0;

        //            mode  dec d0 d1 d2 stall len rnd inj abort keys
        vecs[0] = '{2'b00, 0, 2, 2, 2, -1, 0, 0, 0, -1, 13};
        vecs[1] = '{2'b10, 1, 2, 2, 2, -1, 0, 0, 0, -1, 17};
        vecs[2] = '{2'b01, 0, 2, 2, 2,  5, 3, 0, 0, -1, 15};
        vecs[3] = '{2'b11, 0, 2, 2, 2, -1, 0, 0, 1, -1, 17};
        vecs[4] = '{2'b00, 0, 2, 2, 2, -1, 0, 0, 0,  7,  0};
        vecs[5] = '{2'b00, 0, 2, 2, 2, -1, 0, 0, 0, -1, 13};
        vecs[6] = '{2'b01, 1, 2, 10, 2, -1, 0, 0, 0, -1, 15};
        vecs[7] = '{2'b00, 1, 1, 3, 1, -1, 0, 1, 0, -1, 13};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", all_outs(), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", all_outs(), 0);

        for (int i = 0; i < 8; i++) run(vecs[i]);

        for (int r = 0; r < 6; r++) begin
            vec_t v;
            v.mode      = 2'($urandom_range(0, 3));
            v.dec       = 1'($urandom_range(0, 1));
            v.d0        = $urandom_range(1, 6);
            v.d1        = $urandom_range(1, 6);
            v.d2        = $urandom_range(1, 6);
            v.stall_at  = $urandom_range(0, last_of(v.mode));
            v.stall_len = $urandom_range(1, 4);
            v.rnd_ready = 1'($urandom_range(0, 1));
            v.inject    = 1'($urandom_range(0, 1));
            v.abort_at  = -1;
            v.exp_keys  = last_of(v.mode) + 1;
            run(v);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
